sirc_responder: RTL and testbench
=================================

Name: sirc_responder

Overview:
- Synthesizable responder for the SIRC user-circuit interface: the host side of the handshake that the PUF user FSM drives.
- Owns the run register, a 32-bit parameter register file, the input memory (read by the user) and the output memory (written by the user).
- Serves user req/ack handshakes with fixed read latency; exposes a simple host port for loading challenges and operands and reading responses back.
- Used standalone on-board and as the bench model for every SIRC user circuit.

Parameters:
- NUM_REGS, 4, parameter registers implemented; addresses >= NUM_REGS read 0, writes ignored
- INMEM_BYTE_WIDTH, 1, input memory word width in bytes
- OUTMEM_BYTE_WIDTH, 1, output memory word width in bytes
- INMEM_ADDRESS_WIDTH, 6, input memory depth = 2^N words
- OUTMEM_ADDRESS_WIDTH, 6, output memory depth = 2^N words
- RD_LATENCY, 2, cycles from accepted read to DataValid pulse (>= 1)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-low
- userRunValue  out  1  run register value
- userRunClear  in  1  user clears the run register
- register32CmdReq  in  1  register request
- register32CmdAck  out  1  register acknowledge
- register32WriteData  in  32  register write data
- register32Address  in  8  register address
- register32WriteEn  in  1  1 = write, 0 = read
- register32ReadDataValid  out  1  read-return pulse
- register32ReadData  out  32  read data
- inputMemoryReadReq  in  1  read request
- inputMemoryReadAck  out  1  read acknowledge
- inputMemoryReadAdd  in  INMEM_ADDRESS_WIDTH  read address
- inputMemoryReadDataValid  out  1  read-return pulse
- inputMemoryReadData  out  8*INMEM_BYTE_WIDTH  read data
- outputMemoryWriteReq  in  1  write request
- outputMemoryWriteAck  out  1  write acknowledge
- outputMemoryWriteAdd  in  OUTMEM_ADDRESS_WIDTH  write address
- outputMemoryWriteData  in  8*OUTMEM_BYTE_WIDTH  write data
- outputMemoryWriteByteMask  in  OUTMEM_BYTE_WIDTH  per-byte write enable
- host_run_set  in  1  pulse: set run register
- host_wr_en  in  1  host write strobe
- host_wr_sel  in  1  0 = parameter register, 1 = input memory
- host_wr_addr  in  INMEM_ADDRESS_WIDTH  host write address (low 8 bits used for registers)
- host_wr_data  in  32  host write data (low bytes used for memory)
- host_rd_addr  in  OUTMEM_ADDRESS_WIDTH  output memory readback address
- host_rd_data  out  8*OUTMEM_BYTE_WIDTH  readback data, 1-cycle latency
- out_write_count  out  16  accepted output writes since the last host_run_set; saturates at 16'hFFFF

Behaviour:
- Reset (reset == 0 at a clk edge):
  - all outputs 0; run register 0; parameter registers 0; read pipelines flushed.
  - Memory contents are not cleared.
  - A reset during a transaction drops it: no Ack or Valid appears afterward.
- Run register:
  - host_run_set sets it; userRunClear clears it.
  - If both occur in the same cycle, set wins.
  - host_run_set also zeroes out_write_count.
- Handshake, common to all three channels (one independent instance each):
  - Ack is registered: Ack = 1 in cycle N+1 if Req = 1 in cycle N, Ack = 0 in cycle N, and no reset.
  - A transaction is accepted in a cycle where Req && Ack; address, data and WriteEn are sampled in that cycle.
  - Ack is forced 0 in the cycle after acceptance, so at most one acceptance per 2 cycles.
  - If Req drops before Ack, nothing is accepted; Ack may still pulse for one cycle with no effect.
- Register channel, read:
  - ReadDataValid pulses for exactly 1 cycle, RD_LATENCY cycles after acceptance.
  - ReadData holds the value of reg[addr] as of the acceptance cycle until the next return.
- Register channel, write:
  - Updates reg[addr] on the acceptance edge; no Valid pulse.
- Input memory channel:
  - Same timing as a register read; data = mem[addr].
  - The delay pipeline is RD_LATENCY deep, so overlapping reads return in order.
- Output memory channel:
  - On acceptance, writes only the bytes whose ByteMask bit is 1 at addr.
  - out_write_count increments by 1 on acceptance.
- Host port:
  - host_wr_en writes the selected target in one cycle.
  - Same-cycle conflict with a user register write to the same address: the host value wins.
  - host_rd_data is read-first: a same-cycle user write to host_rd_addr returns the old data.
- Widths: register address compare is on 8 bits; memory addresses wrap naturally modulo depth.

Decomposition:
- Package sirc_pkg: REG_W=32, REG_ADDR_W=8, default RD_LATENCY.
- One sub-module, sirc_hs_slave: the registered-ack generator plus an RD_LATENCY valid/data shift pipeline. It is instantiated three times; the output channel leaves its pipeline unused.

Test Plan:
- Reset: hold reset=0 for 3 cycles during an in-flight register read -> no ReadDataValid after release; all outputs 0.
- Registers: host writes reg0=0, reg1=32'hDEADBEEF; user reads 0 then 1 -> Valid exactly 2 cycles after each acceptance, data 0 then DEADBEEF; Ack never high 2 consecutive cycles.
- Input memory: host loads addr 0..15 with 8'h10+i; user reads sequentially -> 16 returns in order, values 10..1F; address 63 followed by 0 wraps correctly.
- Output memory: user writes 11 bytes 8'hA0+i at addr 0..10 with mask 1 -> host_rd_data returns each byte; out_write_count=11; mask=0 write leaves data unchanged but counts.
- Run register: host_run_set and userRunClear in the same cycle -> userRunValue=1; a later userRunClear alone -> 0.
- Aborted request: Req high 1 cycle then low -> no acceptance, no Valid, memory unchanged.

Source files
------------

// File: rtl/sirc_pkg.sv
// Shared constants for the SIRC host-side responder.
package sirc_pkg;
  localparam int REG_W          = 32;
  localparam int REG_ADDR_W     = 8;
  localparam int RD_LATENCY_DEF = 2;
endpackage

// File: rtl/sirc_hs_slave.sv
// One SIRC handshake channel: registered ack generator plus a fixed-latency
// read-return pipeline (valid pulse and held data).
module sirc_hs_slave #(
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  output logic              o_ack,
  output logic              o_accept,
  input  logic              i_rd_sel,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data
);
  logic                         r_ack;
  logic [LAT-1:0]               r_vld;
  logic [LAT-1:0]               w_in_vld;
  logic [LAT-1:0][DATA_W-1:0]   r_dat;
  logic [LAT-1:0][DATA_W-1:0]   w_in_dat;
  logic                         w_fire;

  // Ack drops for a cycle after every high cycle, so accepts are >= 2 cycles apart.
  always_ff @(posedge clk) begin
    if (!reset) r_ack <= 1'b0;
    else        r_ack <= i_req && !r_ack;
  end

  assign o_ack    = r_ack;
  assign o_accept = i_req && r_ack && reset;
  assign w_fire   = o_accept && i_rd_sel;

  always_comb begin
    w_in_vld    = '0;
    w_in_dat    = '0;
    w_in_vld[0] = w_fire;
    w_in_dat[0] = i_rd_data;
    for (int i = 1; i < LAT; i++) begin
      w_in_vld[i] = r_vld[i-1];
      w_in_dat[i] = r_dat[i-1];
    end
  end

  // The last data stage only loads on a return, so read data holds between returns.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      r_vld <= w_in_vld;
      for (int i = 0; i < LAT; i++) begin
        if ((i < LAT-1) || w_in_vld[i]) r_dat[i] <= w_in_dat[i];
      end
    end
  end

  assign o_rd_valid = r_vld[LAT-1];
  assign o_rd_data  = r_dat[LAT-1];
endmodule

// File: rtl/sirc_responder.sv
// Host side of the SIRC user-circuit interface: run register, parameter
// registers, input/output memories and a simple host load/readback port.
module sirc_responder
  import sirc_pkg::*;
#(
  parameter int NUM_REGS             = 4,
  parameter int INMEM_BYTE_WIDTH     = 1,
  parameter int OUTMEM_BYTE_WIDTH    = 1,
  parameter int INMEM_ADDRESS_WIDTH  = 6,
  parameter int OUTMEM_ADDRESS_WIDTH = 6,
  parameter int RD_LATENCY           = RD_LATENCY_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              userRunValue,
  input  logic                              userRunClear,
  input  logic                              register32CmdReq,
  output logic                              register32CmdAck,
  input  logic [REG_W-1:0]                  register32WriteData,
  input  logic [REG_ADDR_W-1:0]             register32Address,
  input  logic                              register32WriteEn,
  output logic                              register32ReadDataValid,
  output logic [REG_W-1:0]                  register32ReadData,
  input  logic                              inputMemoryReadReq,
  output logic                              inputMemoryReadAck,
  input  logic [INMEM_ADDRESS_WIDTH-1:0]    inputMemoryReadAdd,
  output logic                              inputMemoryReadDataValid,
  output logic [8*INMEM_BYTE_WIDTH-1:0]     inputMemoryReadData,
  input  logic                              outputMemoryWriteReq,
  output logic                              outputMemoryWriteAck,
  input  logic [OUTMEM_ADDRESS_WIDTH-1:0]   outputMemoryWriteAdd,
  input  logic [8*OUTMEM_BYTE_WIDTH-1:0]    outputMemoryWriteData,
  input  logic [OUTMEM_BYTE_WIDTH-1:0]      outputMemoryWriteByteMask,
  input  logic                              host_run_set,
  input  logic                              host_wr_en,
  input  logic                              host_wr_sel,
  input  logic [INMEM_ADDRESS_WIDTH-1:0]    host_wr_addr,
  input  logic [31:0]                       host_wr_data,
  input  logic [OUTMEM_ADDRESS_WIDTH-1:0]   host_rd_addr,
  output logic [8*OUTMEM_BYTE_WIDTH-1:0]    host_rd_data,
  output logic [15:0]                       out_write_count
);
  localparam int IW     = 8*INMEM_BYTE_WIDTH;
  localparam int OW     = 8*OUTMEM_BYTE_WIDTH;
  localparam int IDEPTH = 1 << INMEM_ADDRESS_WIDTH;
  localparam int ODEPTH = 1 << OUTMEM_ADDRESS_WIDTH;

  logic                  r_run;
  logic [15:0]           r_wr_count;
  logic [REG_W-1:0]      r_regs [NUM_REGS];
  logic [IW-1:0]         r_inmem [IDEPTH];
  logic [OW-1:0]         r_outmem [ODEPTH];
  logic [OW-1:0]         r_host_rd;
  logic [REG_W-1:0]      w_reg_rd;
  logic [REG_ADDR_W-1:0] w_host_reg_addr;
  logic                  w_reg_acc;
  logic                  w_in_acc;
  logic                  w_out_acc;

  sirc_hs_slave #(.DATA_W(REG_W), .LAT(RD_LATENCY)) u_reg_hs (
    .clk        (clk),
    .reset      (reset),
    .i_req      (register32CmdReq),
    .o_ack      (register32CmdAck),
    .o_accept   (w_reg_acc),
    .i_rd_sel   (!register32WriteEn),
    .i_rd_data  (w_reg_rd),
    .o_rd_valid (register32ReadDataValid),
    .o_rd_data  (register32ReadData)
  );

  sirc_hs_slave #(.DATA_W(IW), .LAT(RD_LATENCY)) u_in_hs (
    .clk        (clk),
    .reset      (reset),
    .i_req      (inputMemoryReadReq),
    .o_ack      (inputMemoryReadAck),
    .o_accept   (w_in_acc),
    .i_rd_sel   (1'b1),
    .i_rd_data  (r_inmem[inputMemoryReadAdd]),
    .o_rd_valid (inputMemoryReadDataValid),
    .o_rd_data  (inputMemoryReadData)
  );

  // Write-only channel: the return pipeline is left idle and unconnected.
  sirc_hs_slave #(.DATA_W(1), .LAT(1)) u_out_hs (
    .clk        (clk),
    .reset      (reset),
    .i_req      (outputMemoryWriteReq),
    .o_ack      (outputMemoryWriteAck),
    .o_accept   (w_out_acc),
    .i_rd_sel   (1'b0),
    .i_rd_data  (1'b0),
    .o_rd_valid (),
    .o_rd_data  ()
  );

  assign w_host_reg_addr = REG_ADDR_W'(host_wr_addr);

  always_comb begin
    w_reg_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (register32Address == REG_ADDR_W'(i)) w_reg_rd = r_regs[i];
    end
  end

  // Host write is applied after the user write so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_reg_acc && register32WriteEn && (register32Address == REG_ADDR_W'(i)))
          r_regs[i] <= register32WriteData;
        if (host_wr_en && !host_wr_sel && (w_host_reg_addr == REG_ADDR_W'(i)))
          r_regs[i] <= host_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (host_wr_en && host_wr_sel) r_inmem[host_wr_addr] <= IW'(host_wr_data);
  end

  always_ff @(posedge clk) begin
    if (w_out_acc) begin
      for (int b = 0; b < OUTMEM_BYTE_WIDTH; b++) begin
        if (outputMemoryWriteByteMask[b])
          r_outmem[outputMemoryWriteAdd][8*b +: 8] <= outputMemoryWriteData[8*b +: 8];
      end
    end
  end

  // Readback samples the array before any same-edge user write lands.
  always_ff @(posedge clk) begin
    if (!reset) r_host_rd <= '0;
    else        r_host_rd <= r_outmem[host_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_run      <= 1'b0;
      r_wr_count <= '0;
    end else begin
      if (host_run_set)      r_run <= 1'b1;
      else if (userRunClear) r_run <= 1'b0;
      if (host_run_set)
        r_wr_count <= '0;
      else if (w_out_acc && (r_wr_count != 16'hFFFF))
        r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign userRunValue    = r_run;
  assign out_write_count = r_wr_count;
  assign host_rd_data    = r_host_rd;
endmodule

// File: tb/tb_sirc_responder.sv
// Directed self-checking bench for sirc_responder (default parameters).
module tb_sirc_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        userRunValue, userRunClear;
  logic        register32CmdReq, register32CmdAck;
  logic [31:0] register32WriteData;
  logic [7:0]  register32Address;
  logic        register32WriteEn, register32ReadDataValid;
  logic [31:0] register32ReadData;
  logic        inputMemoryReadReq, inputMemoryReadAck;
  logic [5:0]  inputMemoryReadAdd;
  logic        inputMemoryReadDataValid;
  logic [7:0]  inputMemoryReadData;
  logic        outputMemoryWriteReq, outputMemoryWriteAck;
  logic [5:0]  outputMemoryWriteAdd;
  logic [7:0]  outputMemoryWriteData;
  logic        outputMemoryWriteByteMask;
  logic        host_run_set, host_wr_en, host_wr_sel;
  logic [5:0]  host_wr_addr;
  logic [31:0] host_wr_data;
  logic [5:0]  host_rd_addr;
  logic [7:0]  host_rd_data;
  logic [15:0] out_write_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sirc_responder dut (
    .clk                       (clk),
    .reset                     (reset),
    .userRunValue              (userRunValue),
    .userRunClear              (userRunClear),
    .register32CmdReq          (register32CmdReq),
    .register32CmdAck          (register32CmdAck),
    .register32WriteData       (register32WriteData),
    .register32Address         (register32Address),
    .register32WriteEn         (register32WriteEn),
    .register32ReadDataValid   (register32ReadDataValid),
    .register32ReadData        (register32ReadData),
    .inputMemoryReadReq        (inputMemoryReadReq),
    .inputMemoryReadAck        (inputMemoryReadAck),
    .inputMemoryReadAdd        (inputMemoryReadAdd),
    .inputMemoryReadDataValid  (inputMemoryReadDataValid),
    .inputMemoryReadData       (inputMemoryReadData),
    .outputMemoryWriteReq      (outputMemoryWriteReq),
    .outputMemoryWriteAck      (outputMemoryWriteAck),
    .outputMemoryWriteAdd      (outputMemoryWriteAdd),
    .outputMemoryWriteData     (outputMemoryWriteData),
    .outputMemoryWriteByteMask (outputMemoryWriteByteMask),
    .host_run_set              (host_run_set),
    .host_wr_en                (host_wr_en),
    .host_wr_sel               (host_wr_sel),
    .host_wr_addr              (host_wr_addr),
    .host_wr_data              (host_wr_data),
    .host_rd_addr              (host_rd_addr),
    .host_rd_data              (host_rd_data),
    .out_write_count           (out_write_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic sel, input logic [5:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    host_wr_en = 1'b1; host_wr_sel = sel; host_wr_addr = addr; host_wr_data = data;
    @(posedge clk); #1;
    host_wr_en = 1'b0;
  endtask

  // ch=0: register channel, ch=1: input memory channel. Expects Valid exactly 2 cycles after accept.
  task automatic user_read(input bit ch, input logic [7:0] addr, input logic [31:0] exp, input string tag);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (!ch) begin
      register32Address = addr; register32WriteEn = 1'b0; register32CmdReq = 1'b1;
    end else begin
      inputMemoryReadAdd = addr[5:0]; inputMemoryReadReq = 1'b1;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = ch ? inputMemoryReadAck : register32CmdAck;
    end
    check($sformatf("%s_ack", tag), 32'(got), 32'd1);
    @(posedge clk); #1;
    register32CmdReq = 1'b0; inputMemoryReadReq = 1'b0;
    @(negedge clk);
    check($sformatf("%s_v_n1", tag), 32'(ch ? inputMemoryReadDataValid : register32ReadDataValid), 32'd0);
    check($sformatf("%s_ack_n1", tag), 32'(ch ? inputMemoryReadAck : register32CmdAck), 32'd0);
    @(negedge clk);
    check($sformatf("%s_v_n2", tag), 32'(ch ? inputMemoryReadDataValid : register32ReadDataValid), 32'd1);
    check($sformatf("%s_d_n2", tag), ch ? 32'(inputMemoryReadData) : register32ReadData, exp);
    @(negedge clk);
    check($sformatf("%s_v_n3", tag), 32'(ch ? inputMemoryReadDataValid : register32ReadDataValid), 32'd0);
    check($sformatf("%s_hold", tag), ch ? 32'(inputMemoryReadData) : register32ReadData, exp);
  endtask

  task automatic user_out_write(input logic [5:0] addr, input logic [7:0] data, input logic mask);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    outputMemoryWriteAdd = addr; outputMemoryWriteData = data;
    outputMemoryWriteByteMask = mask; outputMemoryWriteReq = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = outputMemoryWriteAck;
    end
    check($sformatf("owr_ack_%0d", addr), 32'(got), 32'd1);
    @(posedge clk); #1;
    outputMemoryWriteReq = 1'b0;
  endtask

  task automatic host_readback(input logic [5:0] addr, input logic [7:0] exp, input string tag);
    @(posedge clk); #1;
    host_rd_addr = addr;
    @(posedge clk);
    @(negedge clk);
    check(tag, 32'(host_rd_data), 32'(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  logic [7:0] exp_b [4];
  int  nacc, nret;
  bit  acc, seen, got;

  initial begin
    reset = 1'b0; userRunClear = 1'b0;
    register32CmdReq = 1'b0; register32WriteData = '0; register32Address = '0; register32WriteEn = 1'b0;
    inputMemoryReadReq = 1'b0; inputMemoryReadAdd = '0;
    outputMemoryWriteReq = 1'b0; outputMemoryWriteAdd = '0; outputMemoryWriteData = '0;
    outputMemoryWriteByteMask = 1'b0;
    host_run_set = 1'b0; host_wr_en = 1'b0; host_wr_sel = 1'b0; host_wr_addr = '0;
    host_wr_data = '0; host_rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Set run so the reset below must clear it; then reset mid-read.
    @(posedge clk); #1 host_run_set = 1'b1;
    @(posedge clk); #1 host_run_set = 1'b0;
    @(negedge clk);
    check("run_pre_reset", 32'(userRunValue), 32'd1);
    register32Address = 8'd0; register32WriteEn = 1'b0; register32CmdReq = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = register32CmdAck;
    end
    check("rst_read_ack", 32'(got), 32'd1);
    @(posedge clk); #1;
    register32CmdReq = 1'b0; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("rst_valid_%0d", i), 32'(register32ReadDataValid), 32'd0);
        check($sformatf("rst_ack_%0d", i), 32'(register32CmdAck | inputMemoryReadAck | outputMemoryWriteAck), 32'd0);
        check($sformatf("rst_run_%0d", i), 32'(userRunValue), 32'd0);
        check($sformatf("rst_cnt_%0d", i), 32'(out_write_count), 32'd0);
        check($sformatf("rst_rdata_%0d", i), register32ReadData, 32'd0);
        check($sformatf("rst_hostrd_%0d", i), 32'(host_rd_data), 32'd0);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (register32ReadDataValid) seen = 1'b1;
    end
    check("rst_no_late_valid", 32'(seen), 32'd0);

    // Parameter registers
    host_write(1'b0, 6'd0, 32'h0);
    host_write(1'b0, 6'd1, 32'hDEADBEEF);
    host_write(1'b0, 6'd5, 32'h55555555);
    user_read(1'b0, 8'd0, 32'h0, "reg0");
    user_read(1'b0, 8'd1, 32'hDEADBEEF, "reg1");
    user_read(1'b0, 8'd5, 32'h0, "reg5_oor");

    // User register write: no Valid pulse, value readable afterward.
    @(posedge clk); #1;
    register32Address = 8'd2; register32WriteData = 32'h12345678;
    register32WriteEn = 1'b1; register32CmdReq = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = register32CmdAck;
    end
    check("regwr_ack", 32'(got), 32'd1);
    @(posedge clk); #1;
    register32CmdReq = 1'b0; register32WriteEn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (register32ReadDataValid) seen = 1'b1;
    end
    check("regwr_no_valid", 32'(seen), 32'd0);
    user_read(1'b0, 8'd2, 32'h12345678, "reg2");

    // Same-cycle host and user write to reg3: host value wins.
    @(posedge clk); #1;
    register32Address = 8'd3; register32WriteData = 32'h00001111;
    register32WriteEn = 1'b1; register32CmdReq = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = register32CmdAck;
    end
    host_wr_en = 1'b1; host_wr_sel = 1'b0; host_wr_addr = 6'd3; host_wr_data = 32'h00002222;
    @(posedge clk); #1;
    register32CmdReq = 1'b0; register32WriteEn = 1'b0; host_wr_en = 1'b0;
    user_read(1'b0, 8'd3, 32'h00002222, "reg3_conflict");

    // Input memory
    for (int i = 0; i < 16; i++) host_write(1'b1, 6'(i), 32'h10 + 32'(i));
    host_write(1'b1, 6'd62, 32'h3E);
    host_write(1'b1, 6'd63, 32'h3F);
    for (int i = 0; i < 16; i++) user_read(1'b1, 8'(i), 32'h10 + 32'(i), $sformatf("imem%0d", i));

    // Back-to-back reads across the wrap: 62, 63, 0, 1 with overlapping returns.
    exp_b[0] = 8'h3E; exp_b[1] = 8'h3F; exp_b[2] = 8'h10; exp_b[3] = 8'h11;
    nacc = 0; nret = 0;
    @(posedge clk); #1;
    inputMemoryReadAdd = 6'd62; inputMemoryReadReq = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc = inputMemoryReadReq && inputMemoryReadAck;
      if (inputMemoryReadDataValid) begin
        if (nret < 4) check($sformatf("burst_%0d", nret), 32'(inputMemoryReadData), 32'(exp_b[nret]));
        nret++;
      end
      if (acc) nacc++;
      @(posedge clk); #1;
      if (acc) begin
        if (nacc == 4) inputMemoryReadReq = 1'b0;
        else inputMemoryReadAdd = inputMemoryReadAdd + 6'd1;
      end
    end
    check("burst_accepts", 32'(nacc), 32'd4);
    check("burst_returns", 32'(nret), 32'd4);

    // Output memory
    for (int i = 0; i < 11; i++) user_out_write(6'(i), 8'hA0 + 8'(i), 1'b1);
    for (int i = 0; i < 11; i++) host_readback(6'(i), 8'hA0 + 8'(i), $sformatf("omem%0d", i));
    check("owr_count_11", 32'(out_write_count), 32'd11);
    user_out_write(6'd3, 8'h55, 1'b0);
    host_readback(6'd3, 8'hA3, "omem3_masked");
    check("owr_count_12", 32'(out_write_count), 32'd12);

    // Read-first: readback of addr 5 in the cycle after the write shows the old byte.
    @(posedge clk); #1;
    host_rd_addr = 6'd5;
    outputMemoryWriteAdd = 6'd5; outputMemoryWriteData = 8'h77;
    outputMemoryWriteByteMask = 1'b1; outputMemoryWriteReq = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = outputMemoryWriteAck;
    end
    check("rf_ack", 32'(got), 32'd1);
    @(posedge clk); #1;
    outputMemoryWriteReq = 1'b0;
    @(negedge clk);
    check("rf_old", 32'(host_rd_data), 32'h000000A5);
    @(negedge clk);
    check("rf_new", 32'(host_rd_data), 32'h00000077);
    check("owr_count_13", 32'(out_write_count), 32'd13);

    // Aborted output write: Req for one cycle only.
    @(posedge clk); #1;
    outputMemoryWriteAdd = 6'd7; outputMemoryWriteData = 8'hFF; outputMemoryWriteReq = 1'b1;
    @(posedge clk); #1;
    outputMemoryWriteReq = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_count", 32'(out_write_count), 32'd13);
    host_readback(6'd7, 8'hA7, "abort_mem");

    // Aborted register read: no Valid.
    @(posedge clk); #1;
    register32Address = 8'd1; register32WriteEn = 1'b0; register32CmdReq = 1'b1;
    @(posedge clk); #1;
    register32CmdReq = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (register32ReadDataValid) seen = 1'b1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);

    // Run register: set beats clear; set also zeroes the write count.
    @(posedge clk); #1;
    host_run_set = 1'b1; userRunClear = 1'b1;
    @(posedge clk); #1;
    host_run_set = 1'b0; userRunClear = 1'b0;
    @(negedge clk);
    check("run_set_wins", 32'(userRunValue), 32'd1);
    check("run_cnt_zero", 32'(out_write_count), 32'd0);
    @(posedge clk); #1 userRunClear = 1'b1;
    @(posedge clk); #1 userRunClear = 1'b0;
    @(negedge clk);
    check("run_cleared", 32'(userRunValue), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
